wb_stage: RTL

WB_STAGE -- requirements
Module: wb_stage

---
 rtl/wb_stage.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - writeback stage: result select, load extraction, load timeout
module wb_stage #(
  parameter int XLEN       = 32,
  parameter int RF_AW      = 5,
  parameter int DM_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [XLEN-1:0]  in_alu,
  input  logic [1:0]       in_wbsel,
  input  logic [2:0]       in_ldtype,
  input  logic [RF_AW-1:0] in_rd,
  input  logic             in_rf_we,
  input  logic [XLEN-1:0]  dm_rdata,
  input  logic             dm_valid,
  output logic             rf_we,
  output logic [RF_AW-1:0] rf_waddr,
  output logic [XLEN-1:0]  rf_wdata,
  output logic             dm_err
);

  // Byte offset within one memory word.
  localparam int OFFW = $clog2(XLEN / 8);

  typedef enum logic {
    IDLE    = 1'b0,
    WAIT_DM = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [RF_AW-1:0]  rd_q, rd_d;
  logic              we_q, we_d;
  logic [2:0]        ldtype_q, ldtype_d;
  logic [OFFW-1:0]   off_q, off_d;
  logic              rf_we_q, rf_we_d;
  logic [RF_AW-1:0]  rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0]   rf_wdata_q, rf_wdata_d;
  logic              dm_err_q, dm_err_d;

  logic [XLEN-1:0]   src_val;
  logic [XLEN-1:0]   shifted;
  logic [XLEN-1:0]   ld_val;
  logic [OFFW-1:0]   off_al;
  logic [7:0]        cnt_inc;

  assign in_ready = (state_q == IDLE);
  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign dm_err   = dm_err_q;

  // Non-load result source: PC+4 (wraps), ALU, or zero for the reserved code.
  always_comb begin
    src_val = '0;
    case (in_wbsel)
      2'b00:   src_val = in_pc + XLEN'(4);
      2'b01:   src_val = in_alu;
      default: src_val = '0;
    endcase
  end

  // Load extraction: align the captured offset to the access size, shift the
  // selected lane down to bit 0, then sign- or zero-extend.
  always_comb begin
    off_al = off_q;
    case (ldtype_q)
      3'b000, 3'b100: off_al = off_q;
      3'b001, 3'b101: off_al = off_q & ~OFFW'(1);
      3'b010, 3'b110: off_al = off_q & ~OFFW'(3);
      default:        off_al = '0;
    endcase
    shifted = dm_rdata >> {off_al, 3'b000};
    ld_val  = shifted;
    case (ldtype_q)
      3'b000:  ld_val = XLEN'($signed(shifted[7:0]));
      3'b001:  ld_val = XLEN'($signed(shifted[15:0]));
      3'b100:  ld_val = XLEN'(shifted[7:0]);
      3'b101:  ld_val = XLEN'(shifted[15:0]);
      3'b010:  ld_val = XLEN'($signed(shifted[31:0]));
      // LWU only exists on 64-bit; on 32-bit it falls back to a full word.
      3'b110:  ld_val = (XLEN == 64) ? XLEN'(shifted[31:0]) : shifted;
      default: ld_val = shifted;
    endcase
  end

  // Next-state logic: accept in IDLE, wait for load data or time out in WAIT_DM.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rd_d       = rd_q;
    we_d       = we_q;
    ldtype_d   = ldtype_q;
    off_d      = off_q;
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    dm_err_d   = 1'b0;
    cnt_inc    = cnt_q + 8'd1;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (in_wbsel == 2'b10) begin
            rd_d     = in_rd;
            we_d     = in_rf_we;
            ldtype_d = in_ldtype;
            off_d    = in_alu[OFFW-1:0];
            cnt_d    = 8'd0;
            state_d  = WAIT_DM;
          end else if (in_rf_we && (in_rd != '0)) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = in_rd;
            rf_wdata_d = src_val;
          end
        end
      end
      WAIT_DM: begin
        if (dm_valid) begin
          // Data arriving on the last allowed cycle still counts.
          if (we_q && (rd_q != '0)) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = rd_q;
            rf_wdata_d = ld_val;
          end
          state_d = IDLE;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == 8'(DM_TIMEOUT)) begin
            dm_err_d = 1'b1;
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset abandons any pending load.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 8'd0;
      rd_q       <= '0;
      we_q       <= 1'b0;
      ldtype_q   <= 3'b000;
      off_q      <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      dm_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_q       <= rd_d;
      we_q       <= we_d;
      ldtype_q   <= ldtype_d;
      off_q      <= off_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      dm_err_q   <= dm_err_d;
    end
  end

endmodule
